// File: rtl/unidade_store_parcial_pkg.sv
// Shared types for the partial-store unit: size codes, FSM states
// and the alignment rule.
package unidade_store_parcial_pkg;

    typedef enum logic [1:0] {
        TAM_WORD = 2'b00,
        TAM_HALF = 2'b01,
        TAM_BYTE = 2'b10,
        TAM_RSV  = 2'b11
    } tamanho_t;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        LER      = 3'd1,
        MESCLAR  = 3'd2,
        ESCREVER = 3'd3,
        FIM      = 3'd4
    } estado_t;

    function automatic logic desalinhado(
        input tamanho_t   tam,
        input logic [1:0] ofs
    );
        logic r;
        unique case (tam)
            TAM_WORD: r = (ofs != 2'b00);
            TAM_HALF: r = ofs[0];
            TAM_BYTE: r = 1'b0;
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/unidade_store_parcial_mesclador_de_bytes.sv
// Narrows a register value to byte/half and merges it into a word lane.
// NARROW_SATURATE_EN selects signed saturation instead of truncation.
module mesclador_de_bytes
    import unidade_store_parcial_pkg::*;
(
    input  logic [31:0] palavra,
    input  logic [31:0] dado,
    input  tamanho_t    tamanho,
    input  logic [1:0]  lane,
    output logic [31:0] palavra_nova,
    output logic        saturou
);

    logic [7:0]  b8;
    logic [15:0] h16;
    logic        sat_b;
    logic        sat_h;

`ifdef NARROW_SATURATE_EN
    always_comb begin
        b8    = dado[7:0];
        h16   = dado[15:0];
        sat_b = 1'b0;
        sat_h = 1'b0;
        if ($signed(dado) > 32'sd127) begin
            b8    = 8'h7F;
            sat_b = 1'b1;
        end else if ($signed(dado) < -32'sd128) begin
            b8    = 8'h80;
            sat_b = 1'b1;
        end
        if ($signed(dado) > 32'sd32767) begin
            h16   = 16'h7FFF;
            sat_h = 1'b1;
        end else if ($signed(dado) < -32'sd32768) begin
            h16   = 16'h8000;
            sat_h = 1'b1;
        end
    end
`else
    logic unused_alto;
    assign unused_alto = ^dado[31:16];
    assign b8    = dado[7:0];
    assign h16   = dado[15:0];
    assign sat_b = 1'b0;
    assign sat_h = 1'b0;
`endif

    always_comb begin
        palavra_nova = palavra;
        saturou      = 1'b0;
        unique case (tamanho)
            TAM_BYTE: begin
                palavra_nova[{lane, 3'b000} +: 8] = b8;
                saturou = sat_b;
            end
            TAM_HALF: begin
                palavra_nova[{lane[1], 4'b0000} +: 16] = h16;
                saturou = sat_h;
            end
            default: palavra_nova = palavra;
        endcase
    end

endmodule

// File: rtl/unidade_store_parcial.sv
// Word/half/byte store unit doing read-modify-write on a word memory.
// Narrowing saturation is enabled by NARROW_SATURATE_EN.
module unidade_store_parcial
    import unidade_store_parcial_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  tamanho,
    input  logic [31:0] endereco,
    input  logic [31:0] dado,
    output logic        ocupado,
    output logic        concluido,
    output logic        erro_alinhamento,
    output logic        erro_timeout,
    output logic        saturou,
    output logic [31:0] mem_endereco,
    output logic        mem_ler,
    output logic        mem_escrever,
    output logic [31:0] mem_dado_escrita,
    input  logic [31:0] mem_dado_leitura,
    input  logic        mem_pronto
);

    localparam int CW = $clog2(TIMEOUT + 1);

    estado_t     estado, prox;
    tamanho_t    tam_r;
    logic [31:0] end_r;
    logic [31:0] dado_r;
    logic [31:0] buffer;
    logic [CW-1:0] cont;
    logic        erro_al_r;
    logic        erro_to_r;
    logic        sat_r;

    tamanho_t    tam_in;
    logic        desal_in;
    logic        esgotou;
    logic [31:0] palavra_nova;
    logic        sat_m;

    assign tam_in   = tamanho_t'(tamanho);
    assign desal_in = desalinhado(tam_in, endereco[1:0]);

    // A late acknowledge in the last allowed cycle still wins over the timeout.
    assign esgotou = (estado == LER || estado == ESCREVER)
                   && !mem_pronto
                   && (cont == CW'(TIMEOUT - 1));

    mesclador_de_bytes u_mesclador (
        .palavra      (buffer),
        .dado         (dado_r),
        .tamanho      (tam_r),
        .lane         (end_r[1:0]),
        .palavra_nova (palavra_nova),
        .saturou      (sat_m)
    );

    always_comb begin
        prox = estado;
        unique case (estado)
            OCIOSO: begin
                if (start) begin
                    if (desal_in)
                        prox = FIM;
                    else if (tam_in == TAM_WORD)
                        prox = ESCREVER;
                    else
                        prox = LER;
                end
            end
            LER: begin
                if (mem_pronto)
                    prox = MESCLAR;
                else if (esgotou)
                    prox = FIM;
            end
            MESCLAR: prox = ESCREVER;
            ESCREVER: begin
                if (mem_pronto || esgotou)
                    prox = FIM;
            end
            FIM:     prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            tam_r     <= TAM_WORD;
            end_r     <= '0;
            dado_r    <= '0;
            buffer    <= '0;
            cont      <= '0;
            erro_al_r <= 1'b0;
            erro_to_r <= 1'b0;
            sat_r     <= 1'b0;
        end else begin
            estado <= prox;
            unique case (estado)
                OCIOSO: begin
                    if (start) begin
                        tam_r     <= tam_in;
                        end_r     <= endereco;
                        dado_r    <= dado;
                        cont      <= '0;
                        erro_al_r <= desal_in;
                        erro_to_r <= 1'b0;
                        sat_r     <= 1'b0;
                        if (tam_in == TAM_WORD)
                            buffer <= dado;
                    end
                end
                LER: begin
                    if (mem_pronto) begin
                        buffer <= mem_dado_leitura;
                        cont   <= '0;
                    end else if (esgotou) begin
                        erro_to_r <= 1'b1;
                        cont      <= '0;
                    end else begin
                        cont <= cont + CW'(1);
                    end
                end
                MESCLAR: begin
                    buffer <= palavra_nova;
                    sat_r  <= sat_m;
                end
                ESCREVER: begin
                    if (mem_pronto) begin
                        cont <= '0;
                    end else if (esgotou) begin
                        erro_to_r <= 1'b1;
                        cont      <= '0;
                    end else begin
                        cont <= cont + CW'(1);
                    end
                end
                default: cont <= '0;
            endcase
        end
    end

    assign ocupado          = (estado != OCIOSO);
    assign concluido        = (estado == FIM);
    assign mem_ler          = (estado == LER);
    assign mem_escrever     = (estado == ESCREVER);
    assign mem_endereco     = {end_r[31:2], 2'b00};
    assign mem_dado_escrita = buffer;
    assign erro_alinhamento = erro_al_r;
    assign erro_timeout     = erro_to_r;
    assign saturou          = sat_r;

endmodule

// File: tb/tb_unidade_store_parcial.sv
// Directed testbench for unidade_store_parcial with a small
// handshaking memory responder driven from the test tasks.
module tb_unidade_store_parcial;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  tamanho;
    logic [31:0] endereco;
    logic [31:0] dado;
    logic        ocupado;
    logic        concluido;
    logic        erro_alinhamento;
    logic        erro_timeout;
    logic        saturou;
    logic [31:0] mem_endereco;
    logic        mem_ler;
    logic        mem_escrever;
    logic [31:0] mem_dado_escrita;
    logic [31:0] mem_dado_leitura;
    logic        mem_pronto;

    int vecs = 0;
    int errs = 0;

    int          r_ler;
    int          r_esc;
    int          r_concl;
    logic [31:0] r_wdata;
    logic [31:0] r_addr;
    logic        r_eal;
    logic        r_eto;
    logic        r_sat;

    always #5 clock = ~clock;

    unidade_store_parcial #(.TIMEOUT(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .tamanho          (tamanho),
        .endereco         (endereco),
        .dado             (dado),
        .ocupado          (ocupado),
        .concluido        (concluido),
        .erro_alinhamento (erro_alinhamento),
        .erro_timeout     (erro_timeout),
        .saturou          (saturou),
        .mem_endereco     (mem_endereco),
        .mem_ler          (mem_ler),
        .mem_escrever     (mem_escrever),
        .mem_dado_escrita (mem_dado_escrita),
        .mem_dado_leitura (mem_dado_leitura),
        .mem_pronto       (mem_pronto)
    );

    // lat: strobe cycles before pronto (0 = first cycle), -1 = never.
    // r_concl counts cycles after the accept edge until concluido.
    task automatic run_op(input logic [1:0] t, input logic [31:0] a,
                          input logic [31:0] d, input int lat,
                          input logic [31:0] mw);
        int wc;
        wc = 0;
        r_ler = 0; r_esc = 0; r_concl = -1;
        r_wdata = '0; r_addr = '0;
        r_eal = 1'b0; r_eto = 1'b0; r_sat = 1'b0;
        @(negedge clock);
        start = 1'b1; tamanho = t; endereco = a; dado = d;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            mem_pronto = 1'b0;
            if (concluido) begin
                r_concl = k;
                r_eal = erro_alinhamento;
                r_eto = erro_timeout;
                r_sat = saturou;
                break;
            end
            if (mem_ler || mem_escrever) begin
                if (mem_ler) r_ler++;
                else begin
                    r_esc++;
                    r_wdata = mem_dado_escrita;
                end
                r_addr = mem_endereco;
                if (lat >= 0 && wc == lat) begin
                    mem_pronto = 1'b1;
                    mem_dado_leitura = mw;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
            @(negedge clock);
        end
        mem_pronto = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; tamanho = 2'b00;
        endereco = '0; dado = '0;
        mem_pronto = 1'b0; mem_dado_leitura = '0;
        repeat (3) @(negedge clock);
        vecs++;
        if ({ocupado, concluido, mem_ler, mem_escrever} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_ctl got %b exp 0000",
                     {ocupado, concluido, mem_ler, mem_escrever});
        end
        vecs++;
        if ({erro_alinhamento, erro_timeout, saturou} !== 3'b000) begin
            errs++;
            $display("FAIL reset_flags got %b exp 000",
                     {erro_alinhamento, erro_timeout, saturou});
        end
        vecs++;
        if ({mem_endereco, mem_dado_escrita} !== 64'h0) begin
            errs++;
            $display("FAIL reset_bus got %h exp 0",
                     {mem_endereco, mem_dado_escrita});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_byte();
        run_op(2'b10, 32'h103, 32'h0000_00AB, 0, 32'h1122_3344);
        vecs++;
        if (r_wdata !== 32'hAB22_3344) begin
            errs++; $display("FAIL sb_data got %h exp AB223344", r_wdata);
        end
        vecs++;
        if (r_addr !== 32'h100) begin
            errs++; $display("FAIL sb_addr got %h exp 00000100", r_addr);
        end
        vecs++;
        if (r_concl !== 4 || r_ler !== 1 || r_esc !== 1) begin
            errs++;
            $display("FAIL sb_timing got c%0d r%0d w%0d exp c4 r1 w1",
                     r_concl, r_ler, r_esc);
        end
        vecs++;
        if ({r_eal, r_eto, r_sat} !== 3'b000) begin
            errs++; $display("FAIL sb_flags got %b exp 000",
                             {r_eal, r_eto, r_sat});
        end
        run_op(2'b10, 32'h200, 32'h1234_5678, 0, 32'h1122_3344);
        vecs++;
`ifdef NARROW_SATURATE_EN
        if (r_wdata !== 32'h1122_337F || r_sat !== 1'b1) begin
            errs++; $display("FAIL sb_lane0 got %h s%b exp 1122337F s1",
                             r_wdata, r_sat);
        end
`else
        if (r_wdata !== 32'h1122_3378 || r_sat !== 1'b0) begin
            errs++; $display("FAIL sb_lane0 got %h s%b exp 11223378 s0",
                             r_wdata, r_sat);
        end
`endif
    endtask

    task automatic test_half();
        run_op(2'b01, 32'h102, 32'h0000_BEEF, 0, 32'h1122_3344);
        vecs++;
`ifdef NARROW_SATURATE_EN
        if (r_wdata !== 32'h7FFF_3344) begin
            errs++; $display("FAIL sh_hi got %h exp 7FFF3344", r_wdata);
        end
`else
        if (r_wdata !== 32'hBEEF_3344) begin
            errs++; $display("FAIL sh_hi got %h exp BEEF3344", r_wdata);
        end
`endif
        run_op(2'b01, 32'h300, 32'hFFFF_BEEF, 0, 32'h1122_3344);
        vecs++;
        if (r_wdata !== 32'h1122_BEEF || r_addr !== 32'h300
            || r_concl !== 4) begin
            errs++; $display("FAIL sh_lo got %h @%h c%0d exp 1122BEEF @300 c4",
                             r_wdata, r_addr, r_concl);
        end
    endtask

    task automatic test_word();
        run_op(2'b00, 32'h100, 32'hDEAD_BEEF, 0, 32'h1122_3344);
        vecs++;
        if (r_wdata !== 32'hDEAD_BEEF || r_ler !== 0 || r_esc !== 1) begin
            errs++; $display("FAIL sw got %h r%0d w%0d exp DEADBEEF r0 w1",
                             r_wdata, r_ler, r_esc);
        end
        vecs++;
        if (r_concl !== 2 || r_eal !== 1'b0) begin
            errs++; $display("FAIL sw_timing got c%0d e%b exp c2 e0",
                             r_concl, r_eal);
        end
    endtask

    task automatic test_misaligned();
        run_op(2'b01, 32'h101, 32'h1234, 0, 32'h0);
        vecs++;
        if (r_ler !== 0 || r_esc !== 0 || r_concl !== 1 || r_eal !== 1'b1) begin
            errs++; $display("FAIL sh_mis got r%0d w%0d c%0d e%b exp r0 w0 c1 e1",
                             r_ler, r_esc, r_concl, r_eal);
        end
        run_op(2'b11, 32'h100, 32'h1234, 0, 32'h0);
        vecs++;
        if (r_ler !== 0 || r_esc !== 0 || r_concl !== 1 || r_eal !== 1'b1) begin
            errs++; $display("FAIL rsv_mis got r%0d w%0d c%0d e%b exp r0 w0 c1 e1",
                             r_ler, r_esc, r_concl, r_eal);
        end
        run_op(2'b00, 32'h102, 32'h1234, 0, 32'h0);
        vecs++;
        if (r_esc !== 0 || r_concl !== 1 || r_eal !== 1'b1) begin
            errs++; $display("FAIL sw_mis got w%0d c%0d e%b exp w0 c1 e1",
                             r_esc, r_concl, r_eal);
        end
        repeat (3) @(negedge clock);
        vecs++;
        if (erro_alinhamento !== 1'b1 || ocupado !== 1'b0) begin
            errs++; $display("FAIL flag_hold got e%b o%b exp e1 o0",
                             erro_alinhamento, ocupado);
        end
    endtask

    task automatic test_wait();
        run_op(2'b10, 32'h401, 32'h0000_0055, 3, 32'hA0B0_C0D0);
        vecs++;
        if (r_wdata !== 32'hA0B0_55D0 || r_ler !== 4 || r_esc !== 4
            || r_concl !== 10) begin
            errs++; $display("FAIL wait got %h r%0d w%0d c%0d exp A0B055D0 r4 w4 c10",
                             r_wdata, r_ler, r_esc, r_concl);
        end
    endtask

    task automatic test_timeout();
        run_op(2'b10, 32'h500, 32'h1, -1, 32'h0);
        vecs++;
        if (r_ler !== 16 || r_esc !== 0 || r_eto !== 1'b1
            || r_concl !== 17) begin
            errs++; $display("FAIL to_read got r%0d w%0d t%b c%0d exp r16 w0 t1 c17",
                             r_ler, r_esc, r_eto, r_concl);
        end
        run_op(2'b00, 32'h500, 32'h1, -1, 32'h0);
        vecs++;
        if (r_esc !== 16 || r_eto !== 1'b1) begin
            errs++; $display("FAIL to_write got w%0d t%b exp w16 t1",
                             r_esc, r_eto);
        end
        run_op(2'b00, 32'h600, 32'h5A5A_5A5A, 15, 32'h0);
        vecs++;
        if (r_esc !== 16 || r_eto !== 1'b0 || r_concl !== 17
            || r_wdata !== 32'h5A5A_5A5A) begin
            errs++; $display("FAIL to_edge got w%0d t%b c%0d %h exp w16 t0 c17 5A5A5A5A",
                             r_esc, r_eto, r_concl, r_wdata);
        end
    endtask

    task automatic test_saturate();
        run_op(2'b10, 32'h700, 32'h0000_0200, 0, 32'h1122_3344);
        vecs++;
`ifdef NARROW_SATURATE_EN
        if (r_wdata !== 32'h1122_337F || r_sat !== 1'b1) begin
            errs++; $display("FAIL sat_pos got %h s%b exp 1122337F s1",
                             r_wdata, r_sat);
        end
`else
        if (r_wdata !== 32'h1122_3300 || r_sat !== 1'b0) begin
            errs++; $display("FAIL sat_pos got %h s%b exp 11223300 s0",
                             r_wdata, r_sat);
        end
`endif
        run_op(2'b10, 32'h700, 32'hFFFF_FF80, 0, 32'h1122_3344);
        vecs++;
        if (r_wdata !== 32'h1122_3380 || r_sat !== 1'b0) begin
            errs++; $display("FAIL sat_min got %h s%b exp 11223380 s0",
                             r_wdata, r_sat);
        end
        run_op(2'b01, 32'h702, 32'hFFFF_0000, 0, 32'h1122_3344);
        vecs++;
`ifdef NARROW_SATURATE_EN
        if (r_wdata !== 32'h8000_3344 || r_sat !== 1'b1) begin
            errs++; $display("FAIL sat_neg got %h s%b exp 80003344 s1",
                             r_wdata, r_sat);
        end
`else
        if (r_wdata !== 32'h0000_3344 || r_sat !== 1'b0) begin
            errs++; $display("FAIL sat_neg got %h s%b exp 00003344 s0",
                             r_wdata, r_sat);
        end
`endif
        run_op(2'b00, 32'h704, 32'h0000_0200, 0, 32'h0);
        vecs++;
        if (r_wdata !== 32'h0000_0200 || r_sat !== 1'b0) begin
            errs++; $display("FAIL sat_word got %h s%b exp 00000200 s0",
                             r_wdata, r_sat);
        end
    endtask

    task automatic test_busy_reset();
        @(negedge clock);
        start = 1'b1; tamanho = 2'b00;
        endereco = 32'h800; dado = 32'hCAFE_F00D;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        vecs++;
        if (ocupado !== 1'b1 || mem_escrever !== 1'b1) begin
            errs++; $display("FAIL busy got o%b w%b exp o1 w1",
                             ocupado, mem_escrever);
        end
        start = 1'b1; tamanho = 2'b10;
        endereco = 32'h900; dado = 32'h1;
        @(negedge clock);
        start = 1'b0;
        vecs++;
        if (mem_endereco !== 32'h800 || mem_dado_escrita !== 32'hCAFE_F00D
            || mem_escrever !== 1'b1) begin
            errs++; $display("FAIL busy_ign got %h %h w%b exp 800 CAFEF00D w1",
                             mem_endereco, mem_dado_escrita, mem_escrever);
        end
        reset = 1'b1;
        @(negedge clock);
        vecs++;
        if ({mem_escrever, ocupado, concluido} !== 3'b000) begin
            errs++; $display("FAIL mid_reset got %b exp 000",
                             {mem_escrever, ocupado, concluido});
        end
        reset = 1'b0;
        @(negedge clock);
        vecs++;
        if ({ocupado, concluido, mem_ler, mem_escrever} !== 4'b0000) begin
            errs++; $display("FAIL post_reset got %b exp 0000",
                             {ocupado, concluido, mem_ler, mem_escrever});
        end
        run_op(2'b00, 32'hA00, 32'h0BAD_CAFE, 0, 32'h0);
        vecs++;
        if (r_wdata !== 32'h0BAD_CAFE || r_concl !== 2) begin
            errs++; $display("FAIL after_reset got %h c%0d exp 0BADCAFE c2",
                             r_wdata, r_concl);
        end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_misaligned();
        test_wait();
        test_timeout();
        test_saturate();
        test_busy_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
